// File: rtl/matmul_loader_if.sv
// Word-stream handshake into the matmul loader (valid/ready).
// master = upstream word source, slave = loader.
interface matmul_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/matmul_loader.sv
// Matmul operand loader: streams matrix X then matrix Y (row-major) into the
// operand memories, kicks the engine with a start pulse, waits for the rising
// edge of its done level and reports completion.
// Optional: MATMUL_LOADER_CHECKSUM_EN adds a running sum of all loaded words.
module matmul_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int VECTOR_SIZE = 8     // N; N*N must equal 2**ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    output logic                  busy,
    output logic                  done,
    matmul_loader_if.slave        strm,
    output logic [DATA_WIDTH-1:0] x_din,
    output logic [ADDR_WIDTH-1:0] x_addr,
    output logic                  x_wr_en,
    output logic [DATA_WIDTH-1:0] y_din,
    output logic [ADDR_WIDTH-1:0] y_addr,
    output logic                  y_wr_en,
    output logic                  mm_start,
    input  logic                  mm_done
`ifdef MATMUL_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);
    localparam int WORDS = VECTOR_SIZE * VECTOR_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_X, S_LOAD_Y, S_START, S_WAIT, S_FINISH
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  mm_done_q;
    logic                  xfer;
    logic                  load_x, load_y;

    assign load_x        = (state == S_LOAD_X);
    assign load_y        = (state == S_LOAD_Y);
    assign strm.in_ready = load_x | load_y;
    assign xfer          = strm.in_valid & strm.in_ready;

    // Memory writes are combinational from the accepted word; data and
    // address are forced to zero when not writing so idle buses stay quiet.
    assign x_wr_en  = load_x & strm.in_valid;
    assign y_wr_en  = load_y & strm.in_valid;
    assign x_addr   = load_x ? cnt : '0;
    assign y_addr   = load_y ? cnt : '0;
    assign x_din    = x_wr_en ? strm.in_data : '0;
    assign y_din    = y_wr_en ? strm.in_data : '0;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FINISH);
    assign mm_start = (state == S_START);

    // State, word counter and engine-done history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mm_done_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mm_done_q <= mm_done;
        end
    end

    // Next-state and counter logic. The counter wraps naturally at N*N,
    // so the end of X leaves it at 0 ready for Y.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt = S_LOAD_X;
                    cnt_nxt   = '0;
                end
            end
            S_LOAD_X, S_LOAD_Y: begin
                if (xfer) begin
                    cnt_nxt = cnt + ADDR_WIDTH'(1);
                    if (cnt == LAST)
                        state_nxt = load_x ? S_LOAD_Y : S_START;
                end
            end
            S_START:  state_nxt = S_WAIT;
            // Only a fresh rising edge counts; a level left over from the
            // previous run is still high until the engine reacts to start.
            S_WAIT:   if (mm_done && !mm_done_q) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

`ifdef MATMUL_LOADER_CHECKSUM_EN
    // Running modulo-2**DATA_WIDTH sum of every accepted word; held after
    // the run until the next accepted go clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            checksum <= '0;
        else if (state == S_IDLE && go)
            checksum <= '0;
        else if (xfer)
            checksum <= checksum + strm.in_data;
    end
`endif

endmodule
